// File: rtl/mouse_transmitter.sv
// PS/2 host-to-device transmitter: inhibits the mouse clock, issues a request-to-send
// and shifts one command byte out on the device's clock, reporting done or error.
module mouse_transmitter #(
    parameter int INHIBIT_CYCLES = 6000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       CLK_MOUSE_IN,
    output logic       CLK_MOUSE_OUT_EN,
    input  logic       DATA_MOUSE_IN,
    output logic       DATA_MOUSE_OUT_EN,
    input  logic       SEND_BYTE,
    input  logic [7:0] BYTE_TO_SEND,
    output logic       BUSY,
    output logic       BYTE_SENT,
    output logic       ERROR
);

    localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        REQ,
        SEND,
        WAIT_ACK,
        WAIT_IDLE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [9:0]       shift_q, shift_d;
    logic             clk_en_q, clk_en_d;
    logic             data_en_q, data_en_d;
    logic             sent_q, sent_d;
    logic             error_q, error_d;

    logic clk_meta, clk_sync, clk_prev;
    logic data_meta, data_sync;
    logic clk_fall;
    logic timeout;

    // Synchronisers come out of reset at the idle (high) line level so that
    // reset itself never looks like a clock fall.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            clk_meta  <= 1'b1;
            clk_sync  <= 1'b1;
            clk_prev  <= 1'b1;
            data_meta <= 1'b1;
            data_sync <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments let each flop sample the previous
            // stage's old value, which is what makes this a real shift chain.
            clk_meta  <= CLK_MOUSE_IN;
            clk_sync  <= clk_meta;
            clk_prev  <= clk_sync;
            data_meta <= DATA_MOUSE_IN;
            data_sync <= data_meta;
        end
    end

    assign clk_fall = clk_prev & ~clk_sync;
    assign timeout  = (cnt_q == TIMEOUT_LAST);

    always_comb begin
        // NOTE: every variable gets its hold/default value first, so no path
        // through the case below can leave one unassigned and infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        clk_en_d  = clk_en_q;
        data_en_d = data_en_q;
        sent_d    = 1'b0;
        error_d   = 1'b0;

        case (state_q)
            IDLE: begin
                clk_en_d  = 1'b0;
                data_en_d = 1'b0;
                if (SEND_BYTE) begin
                    shift_d   = {1'b1, ~^BYTE_TO_SEND, BYTE_TO_SEND};
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    clk_en_d  = 1'b1;
                    state_d   = INHIBIT;
                end
            end
            INHIBIT: begin
                if (cnt_q == INHIBIT_LAST) begin
                    data_en_d = 1'b1;
                    state_d   = REQ;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REQ: begin
                clk_en_d = 1'b0;
                cnt_d    = '0;
                state_d  = SEND;
            end
            SEND, WAIT_ACK, WAIT_IDLE: begin
                if (timeout) begin
                    error_d   = 1'b1;
                    clk_en_d  = 1'b0;
                    data_en_d = 1'b0;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (state_q == SEND) begin
                        if (clk_fall) begin
                            data_en_d = ~shift_q[bit_idx_q];
                            bit_idx_d = bit_idx_q + 4'd1;
                            if (bit_idx_q == 4'd9)
                                state_d = WAIT_ACK;
                        end
                    end else if (state_q == WAIT_ACK) begin
                        if (clk_fall) begin
                            if (!data_sync) begin
                                state_d = WAIT_IDLE;
                            end else begin
                                error_d = 1'b1;
                                state_d = IDLE;
                            end
                        end
                    end else if (clk_sync && data_sync) begin
                        sent_d  = 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                clk_en_d  = 1'b0;
                data_en_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            clk_en_q  <= 1'b0;
            data_en_q <= 1'b0;
            sent_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            clk_en_q  <= clk_en_d;
            data_en_q <= data_en_d;
            sent_q    <= sent_d;
            error_q   <= error_d;
        end
    end

    assign CLK_MOUSE_OUT_EN  = clk_en_q;
    assign DATA_MOUSE_OUT_EN = data_en_q;
    assign BUSY              = (state_q != IDLE);
    assign BYTE_SENT         = sent_q;
    assign ERROR             = error_q;

endmodule

// File: doc/mouse_transmitter.md
# mouse_transmitter

Host-to-device PS/2 transmitter for the mouse port. It sends one command byte to the mouse, for example 0xFF (reset) or 0xF4 (enable data reporting), and returns a done or error indication. It sits beside the PS/2 receiver inside the mouse transceiver. Both blocks share the open-drain CLK_MOUSE and DATA_MOUSE lines: the transceiver merges the enables from this block into the tristate drivers, and this block only drives a line low or releases it.

## Interface
- INHIBIT_CYCLES, default 6000: number of CLK cycles CLK_MOUSE is held low before the request (120 us at 50 MHz).
- TIMEOUT_CYCLES, default 1000000: abort limit in CLK cycles (20 ms), counted from release of the clock line.
- CLK  input  1  system clock; the block uses a single clock.
- RESET  input  1  synchronous reset, active-high.
- CLK_MOUSE_IN  input  1  raw (asynchronous) level of the PS/2 clock line.
- CLK_MOUSE_OUT_EN  output  1  1 = pull CLK_MOUSE low.
- DATA_MOUSE_IN  input  1  raw (asynchronous) level of the PS/2 data line.
- DATA_MOUSE_OUT_EN  output  1  1 = pull DATA_MOUSE low. The external driver always drives 0 when enabled.
- SEND_BYTE  input  1  start request; sampled only in IDLE.
- BYTE_TO_SEND  input  8  command byte; latched on the accepting cycle.
- BUSY  output  1  high from the cycle after acceptance until return to IDLE.
- BYTE_SENT  output  1  one-cycle pulse when the device ACKs and the bus returns to idle.
- ERROR  output  1  one-cycle pulse on NACK or timeout.

## Operation
- Input synchronisation:
  - Both raw inputs pass through a 2-flop synchroniser plus one history flop.
  - fall = prev 1 and sync 0.
  - All decisions use the synchronised values.
- Shift register: {stop=1, parity, D7..D0}, sent LSB first. parity = ~^BYTE_TO_SEND (odd parity).
- States and transitions:
  - IDLE: both enables 0. On SEND_BYTE, latch the byte, clear counters, go to INHIBIT.
  - INHIBIT: CLK_MOUSE_OUT_EN = 1. Count INHIBIT_CYCLES, then set DATA_MOUSE_OUT_EN = 1 (start bit) and go to REQ.
  - REQ: one cycle with data still low and CLK_MOUSE_OUT_EN = 0 (clock released). Clear the timeout counter; go to SEND.
  - SEND: on each fall, DATA_MOUSE_OUT_EN = ~current bit and the bit index increments.
    - Falls 1–8 put out D0..D7.
    - Fall 9 puts out parity.
    - Fall 10 puts out stop: the data line is released.
    - After fall 10, go to WAIT_ACK.
  - WAIT_ACK: on the next fall, sample the synchronised data line.
    - 0: go to WAIT_IDLE.
    - 1: NACK; pulse ERROR and go to IDLE.
  - WAIT_IDLE: when the synchronised clock and data are both 1, pulse BYTE_SENT and go to IDLE.
- Timeout: in REQ, SEND, WAIT_ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES does all of the following in the same cycle:
  - pulses ERROR;
  - releases both lines;
  - goes to IDLE.
- The block never drives a line high. Both enables are 0 in IDLE, WAIT_ACK and WAIT_IDLE.
- While BUSY, SEND_BYTE is ignored and not queued.
- A fall seen during INHIBIT or REQ is ignored.

## Timing
- Reset values: BUSY = 0, BYTE_SENT = 0, ERROR = 0, both enables = 0, state = IDLE, counters = 0.
- Reset mid-frame: both lines are released on the clock edge where RESET is sampled. No BYTE_SENT or ERROR pulse is produced.
- Acceptance:
  - SEND_BYTE is high in cycle N.
  - BUSY = 1 and CLK_MOUSE_OUT_EN = 1 from N+1.
  - DATA_MOUSE_OUT_EN = 1 from N+1+INHIBIT_CYCLES.
  - Clock is released at N+2+INHIBIT_CYCLES.
- Data update latency: DATA_MOUSE_OUT_EN changes 3 CLK cycles after the raw CLK_MOUSE_IN falls. This is well inside the ≥30 us clock-low half period.
- Completion: BYTE_SENT or ERROR is asserted for exactly 1 cycle. BUSY is 0 in the cycle after the pulse. A new SEND_BYTE is accepted in that same cycle.
- BYTE_SENT and ERROR are never asserted together.

## Test plan
- Send 0xF4, with the device model clocking at 12.5 kHz and ACKing with 0:
  - bits at falls 1–9 are 0,0,1,0,1,1,1,1 then parity 0;
  - data is released at fall 10;
  - BYTE_SENT pulses once and ERROR stays 0.
- Send 0xFF: parity bit is 1, the inhibit low time is ≥ 6000 cycles, and BYTE_SENT pulses once.
- Send 0x00 with the device holding data high at the ACK fall: ERROR pulses once, there is no BYTE_SENT, and both enables are 0 afterwards.
- Send 0xF4 with a device that never clocks: ERROR pulses exactly 1000000 cycles after the clock release, and BUSY then drops to 0.
- Assert RESET after fall 5 of a frame: both enables go to 0 on the next edge, with no pulses. A following 0xF4 send completes normally.
- Pulse SEND_BYTE with 0x55 during SEND for 0xF4: it is ignored, and the line carries the 0xF4 frame unchanged.
